// File: rtl/conv_job_scheduler.sv
// Round-robin scheduler that shares one conv2d unit between NREQ requesters,
// with a start/done handshake, a watchdog timeout and a tagged response.
module conv_job_scheduler #(
  parameter int NREQ      = 4,
  parameter int TO_CYCLES = 65535
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NREQ-1:0]         req_valid,
  input  logic [NREQ*256-1:0]     req_desc,
  output logic [NREQ-1:0]         req_ready,
  output logic                    cu_start,
  output logic [31:0]             cu_input_ptr,
  output logic [31:0]             cu_filter_ptr,
  output logic [31:0]             cu_output_ptr,
  output logic [31:0]             cu_input_dims,
  output logic [31:0]             cu_filter_dims,
  output logic [31:0]             cu_output_dims,
  output logic [31:0]             cu_stride,
  output logic [31:0]             cu_padding,
  input  logic                    cu_ready,
  input  logic                    cu_done,
  input  logic [31:0]             cu_result,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [$clog2(NREQ)-1:0] rsp_id,
  output logic [31:0]             rsp_result,
  output logic                    rsp_timeout,
  output logic                    busy,
  output logic [15:0]             jobs_done,
  output logic [15:0]             timeouts
);

  localparam int IW = $clog2(NREQ);
  localparam int CW = $clog2(TO_CYCLES);
  localparam logic [CW-1:0] WD_ONE  = CW'(1);
  localparam logic [CW-1:0] WD_LAST = CW'(TO_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_LAUNCH, S_WAIT, S_RESP} state_t;

  state_t          state_r;
  logic [IW-1:0]   last_grant_r;
  logic [IW-1:0]   rsp_id_r;
  logic [CW-1:0]   wd_cnt_r;
  logic [255:0]    desc_r;
  logic            cu_start_r;
  logic            rsp_valid_r;
  logic [31:0]     rsp_result_r;
  logic            rsp_timeout_r;
  logic [15:0]     jobs_done_r;
  logic [15:0]     timeouts_r;

  logic            grant_found_s;
  logic [IW-1:0]   grant_idx_s;
  logic            accept_s;
  logic [NREQ-1:0] req_ready_s;
  int              cand_s;

  // Round-robin search starting just after the last requester served
  always_comb begin
    grant_found_s = 1'b0;
    grant_idx_s   = {IW{1'b0}};
    cand_s        = 0;
    for (int k = 1; k <= NREQ; k++) begin
      cand_s = int'(last_grant_r) + k;
      if (cand_s >= NREQ) begin
        cand_s = cand_s - NREQ;
      end else begin
        cand_s = cand_s;
      end
      if (!grant_found_s && req_valid[cand_s]) begin
        grant_found_s = 1'b1;
        grant_idx_s   = IW'(cand_s);
      end else begin
        grant_found_s = grant_found_s;
      end
    end
  end

  // Accept pulse is same-cycle so the requester can drop valid right after it
  always_comb begin
    accept_s    = (state_r == S_IDLE) && grant_found_s && cu_ready && rst_n;
    req_ready_s = {NREQ{1'b0}};
    if (accept_s) begin
      req_ready_s[grant_idx_s] = 1'b1;
    end else begin
      req_ready_s = {NREQ{1'b0}};
    end
  end

  // Job FSM, descriptor latch, watchdog and completion counters
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r       <= S_IDLE;
      last_grant_r  <= IW'(NREQ - 1);
      rsp_id_r      <= {IW{1'b0}};
      wd_cnt_r      <= {CW{1'b0}};
      desc_r        <= {256{1'b0}};
      cu_start_r    <= 1'b0;
      rsp_valid_r   <= 1'b0;
      rsp_result_r  <= 32'h0000_0000;
      rsp_timeout_r <= 1'b0;
      jobs_done_r   <= 16'h0000;
      timeouts_r    <= 16'h0000;
    end else begin
      case (state_r)
        S_IDLE: begin
          cu_start_r <= accept_s;
          if (accept_s) begin
            desc_r   <= req_desc[int'(grant_idx_s)*256 +: 256];
            rsp_id_r <= grant_idx_s;
            state_r  <= S_LAUNCH;
          end else begin
            state_r  <= S_IDLE;
          end
        end
        S_LAUNCH: begin
          cu_start_r <= 1'b0;
          wd_cnt_r   <= {CW{1'b0}};
          state_r    <= S_WAIT;
        end
        S_WAIT: begin
          // done takes precedence over a watchdog expiry in the same cycle
          if (cu_done) begin
            rsp_result_r  <= cu_result;
            rsp_timeout_r <= 1'b0;
            rsp_valid_r   <= 1'b1;
            state_r       <= S_RESP;
          end else if (wd_cnt_r == WD_LAST) begin
            rsp_result_r  <= 32'h0000_0000;
            rsp_timeout_r <= 1'b1;
            rsp_valid_r   <= 1'b1;
            state_r       <= S_RESP;
          end else begin
            wd_cnt_r      <= wd_cnt_r + WD_ONE;
          end
        end
        S_RESP: begin
          if (rsp_ready) begin
            rsp_valid_r  <= 1'b0;
            last_grant_r <= rsp_id_r;
            state_r      <= S_IDLE;
            if (rsp_timeout_r) begin
              if (timeouts_r != 16'hFFFF) begin
                timeouts_r <= timeouts_r + 16'h0001;
              end else begin
                timeouts_r <= timeouts_r;
              end
            end else begin
              if (jobs_done_r != 16'hFFFF) begin
                jobs_done_r <= jobs_done_r + 16'h0001;
              end else begin
                jobs_done_r <= jobs_done_r;
              end
            end
          end else begin
            state_r <= S_RESP;
          end
        end
        default: begin
          state_r <= S_IDLE;
        end
      endcase
    end
  end

  assign req_ready      = req_ready_s;
  assign cu_start       = cu_start_r;
  assign cu_input_ptr   = desc_r[31:0];
  assign cu_filter_ptr  = desc_r[63:32];
  assign cu_output_ptr  = desc_r[95:64];
  assign cu_input_dims  = desc_r[127:96];
  assign cu_filter_dims = desc_r[159:128];
  assign cu_output_dims = desc_r[191:160];
  assign cu_stride      = desc_r[223:192];
  assign cu_padding     = desc_r[255:224];
  assign rsp_valid      = rsp_valid_r;
  assign rsp_id         = rsp_id_r;
  assign rsp_result     = rsp_result_r;
  assign rsp_timeout    = rsp_timeout_r;
  assign busy           = (state_r != S_IDLE);
  assign jobs_done      = jobs_done_r;
  assign timeouts       = timeouts_r;

endmodule

// File: tb/tb_conv_job_scheduler.sv
// Directed bench for conv_job_scheduler: grant order, handshake timing,
// watchdog boundary, response stall and reset abandonment.
module tb_conv_job_scheduler;

  localparam int NREQ = 4;
  localparam int TO   = 100;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ*256-1:0] req_desc;
  logic [NREQ-1:0]   req_ready;
  logic              cu_start;
  logic [31:0]       cu_input_ptr, cu_filter_ptr, cu_output_ptr, cu_input_dims;
  logic [31:0]       cu_filter_dims, cu_output_dims, cu_stride, cu_padding;
  logic              cu_ready, cu_done;
  logic [31:0]       cu_result;
  logic              rsp_valid, rsp_ready;
  logic [1:0]        rsp_id;
  logic [31:0]       rsp_result;
  logic              rsp_timeout, busy;
  logic [15:0]       jobs_done, timeouts;

  int n_cmp = 0;
  int n_err = 0;
  int exp_done = 0;
  int exp_tos  = 0;

  conv_job_scheduler #(.NREQ(NREQ), .TO_CYCLES(TO)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_desc(req_desc),
    .req_ready(req_ready), .cu_start(cu_start),
    .cu_input_ptr(cu_input_ptr), .cu_filter_ptr(cu_filter_ptr),
    .cu_output_ptr(cu_output_ptr), .cu_input_dims(cu_input_dims),
    .cu_filter_dims(cu_filter_dims), .cu_output_dims(cu_output_dims),
    .cu_stride(cu_stride), .cu_padding(cu_padding),
    .cu_ready(cu_ready), .cu_done(cu_done), .cu_result(cu_result),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_result(rsp_result), .rsp_timeout(rsp_timeout), .busy(busy),
    .jobs_done(jobs_done), .timeouts(timeouts)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  function automatic logic [31:0] dw(input int i, input int j);
    return 32'hA000_0000 + 32'(i * 16 + j);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    adv();
    adv();
    chk("rst_req_ready", 32'(req_ready), 32'h0);
    chk("rst_cu_start", 32'(cu_start), 32'h0);
    chk("rst_cu_in_ptr", cu_input_ptr, 32'h0);
    chk("rst_cu_padding", cu_padding, 32'h0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("rst_rsp_id", 32'(rsp_id), 32'h0);
    chk("rst_rsp_result", rsp_result, 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_jobs_done", 32'(jobs_done), 32'h0);
    chk("rst_timeouts", 32'(timeouts), 32'h0);
    exp_done = 0;
    exp_tos  = 0;
    rst_n = 1'b1;
  endtask

  // One job: accept of requester g, n WAIT cycles, then done (or watchdog), stall cycles of rsp backpressure
  task automatic do_job(input int g, input int n, input bit done, input logic [31:0] res, input int stall);
    logic [31:0] exp_res;
    exp_res = done ? res : 32'h0;
    #1;
    for (int w = 0; w < 20 && req_ready == 4'b0000; w++) adv();
    chk("grant", 32'(req_ready), 32'h1 << g);
    adv();
    chk("launch_start", 32'(cu_start), 32'h1);
    chk("launch_busy", 32'(busy), 32'h1);
    chk("launch_in_ptr", cu_input_ptr, dw(g, 0));
    chk("launch_stride", cu_stride, dw(g, 6));
    chk("launch_padding", cu_padding, dw(g, 7));
    cu_result = res;
    repeat (n) adv();
    chk("wait_no_rsp", 32'(rsp_valid), 32'h0);
    cu_done = done;
    adv();
    cu_done = 1'b0;
    for (int s = 0; s <= stall; s++) begin
      chk("rsp_valid", 32'(rsp_valid), 32'h1);
      chk("rsp_id", 32'(rsp_id), 32'(g));
      chk("rsp_result", rsp_result, exp_res);
      chk("rsp_timeout", 32'(rsp_timeout), 32'(!done));
      chk("rsp_no_grant", 32'(req_ready), 32'h0);
      chk("rsp_busy", 32'(busy), 32'h1);
      if (s < stall) adv();
    end
    rsp_ready = 1'b1;
    adv();
    rsp_ready = 1'b0;
    if (done) exp_done++; else exp_tos++;
    chk("post_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("post_busy", 32'(busy), 32'h0);
    chk("jobs_done", 32'(jobs_done), 32'(exp_done));
    chk("timeouts", 32'(timeouts), 32'(exp_tos));
  endtask

  initial begin
    rst_n = 1'b0;
    req_valid = 4'b0000;
    cu_ready = 1'b1;
    cu_done = 1'b0;
    cu_result = 32'h0;
    rsp_ready = 1'b0;
    for (int i = 0; i < NREQ; i++)
      for (int j = 0; j < 8; j++)
        req_desc[i*256 + j*32 +: 32] = dw(i, j);

    // T1: single requester, done 10 cycles after start
    do_reset();
    req_valid = 4'b0010;
    do_job(1, 10, 1'b1, 32'h0000_1234, 0);
    req_valid = 4'b0000;

    // T2 + T4: all requesting, 3-cycle unit, last job stalls its response 5 cycles
    do_reset();
    req_valid = 4'b1111;
    do_job(0, 3, 1'b1, 32'h0000_0A00, 0);
    do_job(1, 3, 1'b1, 32'h0000_0A01, 0);
    do_job(2, 3, 1'b1, 32'h0000_0A02, 0);
    do_job(3, 3, 1'b1, 32'h0000_0A03, 0);
    do_job(0, 3, 1'b1, 32'h0000_0A04, 5);

    // T3: no done ever -> timeout after 100 WAIT cycles; unit still not ready afterwards
    do_job(1, TO, 1'b0, 32'h0000_DEAD, 0);
    cu_ready = 1'b0;
    #1;
    chk("cu_busy_no_accept", 32'(req_ready), 32'h0);
    repeat (3) adv();
    chk("cu_busy_idle", 32'(busy), 32'h0);
    cu_ready = 1'b1;

    // T5: done on the final watchdog cycle wins
    do_job(2, TO, 1'b1, 32'h0000_BEEF, 0);

    // T6: reset during WAIT abandons the job
    req_valid = 4'b1000;
    #1;
    chk("t6_grant", 32'(req_ready), 32'h8);
    adv();
    adv();
    adv();
    rst_n = 1'b0;
    adv();
    chk("t6_rst_ready", 32'(req_ready), 32'h0);
    chk("t6_rst_start", 32'(cu_start), 32'h0);
    chk("t6_rst_in_ptr", cu_input_ptr, 32'h0);
    chk("t6_rst_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("t6_rst_busy", 32'(busy), 32'h0);
    chk("t6_rst_jobs", 32'(jobs_done), 32'h0);
    chk("t6_rst_tos", 32'(timeouts), 32'h0);
    exp_done = 0;
    exp_tos  = 0;
    rst_n = 1'b1;
    req_valid = 4'b1111;
    cu_ready = 1'b0;
    #1;
    chk("t6_no_ready_accept", 32'(req_ready), 32'h0);
    repeat (2) adv();
    chk("t6_still_idle", 32'(busy), 32'h0);
    chk("t6_no_rsp", 32'(rsp_valid), 32'h0);
    cu_ready = 1'b1;
    do_job(0, 3, 1'b1, 32'h0000_5A5A, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
